// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and default sizes for the hazard/forwarding controller
// Contents: fwd_sel_t operand-source encoding, default register count and index width.
package hazard_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;
  localparam int NREG_DEF = 32;
  localparam int RW_DEF   = $clog2(NREG_DEF);
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending bits for outstanding long-latency ops
// Ports: clk/rst (async active-high); i_set/i_set_dest mark a register pending;
// i_clr/i_clr_dest release it; o_pending exposes the NREG-bit scoreboard.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_set,
  input  logic [RW-1:0]   i_set_dest,
  input  logic            i_clr,
  input  logic [RW-1:0]   i_clr_dest,
  output logic [NREG-1:0] o_pending
);
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_next;
  // set is applied after clear so a same-cycle set/clear on one register leaves it pending
  always_comb begin
    w_next = '0;
    for (int k = 1; k < NREG; k++)
      w_next[k] = (i_set && i_set_dest == RW'(k)) ||
                  (r_pending[k] && !(i_clr && i_clr_dest == RW'(k)));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pending <= '0;
    else     r_pending <= w_next;
  assign o_pending = r_pending;
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: RAW forwarding select, load-use/scoreboard/WAW stall, stall counter and hang watchdog
// Ports: rsel_dec/ren_dec decode reads; wsel_*/wen_* EX/MEM/WB writers; memread_ex load in EX;
// lng_* long-latency issue/complete; flush; outputs stall, fwd_sel (2 bits/port),
// pending scoreboard, saturating stall_cnt, sticky hang.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int NREAD   = 2,
  parameter int NREG    = NREG_DEF,
  parameter int RW      = $clog2(NREG),
  parameter int CW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*RW-1:0] rsel_dec,
  input  logic [NREAD-1:0]    ren_dec,
  input  logic [RW-1:0]       wsel_ex,
  input  logic [RW-1:0]       wsel_mem,
  input  logic [RW-1:0]       wsel_wb,
  input  logic                wen_ex,
  input  logic                wen_mem,
  input  logic                wen_wb,
  input  logic                memread_ex,
  input  logic                lng_issue,
  input  logic [RW-1:0]       lng_dest,
  input  logic                lng_done,
  input  logic [RW-1:0]       lng_done_dest,
  input  logic                flush,
  output logic                stall,
  output logic [NREAD*2-1:0]  fwd_sel,
  output logic [NREG-1:0]     pending,
  output logic [CW-1:0]       stall_cnt,
  output logic                hang
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [NREAD-1:0] w_lu;
  logic [NREAD-1:0] w_sb;
  logic             w_waw;
  logic             w_set;
  logic [TW-1:0]    r_run;
  logic [CW-1:0]    r_stall_cnt;
  logic             r_hang;
  for (genvar i = 0; i < NREAD; i++) begin : g_port
    logic [RW-1:0] w_rsel;
    logic          w_act;
    logic          w_ex;
    logic          w_mem;
    logic          w_wb;
    fwd_sel_t      w_fwd;
    assign w_rsel = rsel_dec[i*RW +: RW];
    assign w_act  = ren_dec[i] && w_rsel != '0;
    assign w_ex   = w_act && wen_ex  && wsel_ex  == w_rsel;
    assign w_mem  = w_act && wen_mem && wsel_mem == w_rsel;
    assign w_wb   = w_act && wen_wb  && wsel_wb  == w_rsel;
    // youngest producer wins; a load in EX still reports EX while the stall holds decode
    assign w_fwd  = w_ex ? FWD_EX : w_mem ? FWD_MEM : w_wb ? FWD_WB : FWD_RF;
    assign fwd_sel[i*2 +: 2] = w_fwd;
    assign w_lu[i] = w_ex && memread_ex;
    assign w_sb[i] = w_act && pending[w_rsel];
  end
  assign w_waw = lng_issue && pending[lng_dest];
  assign stall = (|w_lu) || (|w_sb) || w_waw;
  assign w_set = lng_issue && !stall && !flush && lng_dest != '0;
  hazard_scoreboard #(.NREG(NREG), .RW(RW)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set      (w_set),
    .i_set_dest (lng_dest),
    .i_clr      (lng_done),
    .i_clr_dest (lng_done_dest),
    .o_pending  (pending)
  );
  // hang latches on the edge that completes the TIMEOUT-th consecutive stall cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_stall_cnt <= '0;
      r_run       <= '0;
      r_hang      <= 1'b0;
    end else begin
      if (stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CW'(1);
      r_run <= !stall ? '0 : (r_run == TW'(TIMEOUT)) ? r_run : r_run + TW'(1);
      if (stall && r_run >= TW'(TIMEOUT - 1)) r_hang <= 1'b1;
    end
  assign stall_cnt = r_stall_cnt;
  assign hang      = r_hang;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed and randomized check of hazard_fwd_unit against a rule-level model
module tb_hazard_fwd_unit;
  localparam int NREAD = 2;
  localparam int NREG  = 32;
  localparam int RW    = 5;
  localparam int CW    = 32;
  localparam int TO    = 16;
  logic                clk;
  logic                rst;
  logic [NREAD*RW-1:0] rsel_dec;
  logic [NREAD-1:0]    ren_dec;
  logic [RW-1:0]       wsel_ex, wsel_mem, wsel_wb;
  logic                wen_ex, wen_mem, wen_wb;
  logic                memread_ex;
  logic                lng_issue;
  logic [RW-1:0]       lng_dest;
  logic                lng_done;
  logic [RW-1:0]       lng_done_dest;
  logic                flush;
  logic                stall;
  logic [NREAD*2-1:0]  fwd_sel;
  logic [NREG-1:0]     pending;
  logic [CW-1:0]       stall_cnt;
  logic                hang;
  int tests = 0;
  int fails = 0;
  bit          m_pend [NREG];
  longint      m_cnt;
  int          m_run;
  bit          m_hang;
  hazard_fwd_unit #(.NREAD(NREAD), .NREG(NREG), .RW(RW), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rsel_dec(rsel_dec), .ren_dec(ren_dec),
    .wsel_ex(wsel_ex), .wsel_mem(wsel_mem), .wsel_wb(wsel_wb),
    .wen_ex(wen_ex), .wen_mem(wen_mem), .wen_wb(wen_wb), .memread_ex(memread_ex),
    .lng_issue(lng_issue), .lng_dest(lng_dest), .lng_done(lng_done),
    .lng_done_dest(lng_done_dest), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
    .pending(pending), .stall_cnt(stall_cnt), .hang(hang)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    rsel_dec = '0; ren_dec = '0;
    wsel_ex = '0; wsel_mem = '0; wsel_wb = '0;
    wen_ex = 1'b0; wen_mem = 1'b0; wen_wb = 1'b0; memread_ex = 1'b0;
    lng_issue = 1'b0; lng_dest = '0; lng_done = 1'b0; lng_done_dest = '0; flush = 1'b0;
  endtask
  task automatic rd(input int p, input int r);
    rsel_dec[p*RW +: RW] = RW'(r);
    ren_dec[p] = 1'b1;
  endtask
  task automatic model_reset();
    foreach (m_pend[k]) m_pend[k] = 1'b0;
    m_cnt = 0; m_run = 0; m_hang = 1'b0;
  endtask
  // reference: each rule of the operand-source and stall definitions evaluated directly
  function automatic void model(output logic e_stall, output logic [NREAD*2-1:0] e_fwd);
    e_stall = lng_issue && m_pend[lng_dest];
    e_fwd = '0;
    for (int p = 0; p < NREAD; p++) begin
      int r = int'(rsel_dec[p*RW +: RW]);
      int src = 0;
      if (ren_dec[p] && r != 0) begin
        if (wen_ex && int'(wsel_ex) == r) src = 1;
        else if (wen_mem && int'(wsel_mem) == r) src = 2;
        else if (wen_wb && int'(wsel_wb) == r) src = 3;
        if (src == 1 && memread_ex) e_stall = 1'b1;
        if (m_pend[r]) e_stall = 1'b1;
      end
      e_fwd[p*2 +: 2] = 2'(src);
    end
  endfunction
  task automatic comb_check();
    logic es;
    logic [NREAD*2-1:0] ef;
    #2;
    model(es, ef);
    chk("stall", 64'(stall), 64'(es));
    chk("fwd_sel", 64'(fwd_sel), 64'(ef));
  endtask
  task automatic clk_step();
    logic es;
    logic [NREAD*2-1:0] ef;
    logic [NREG-1:0] ep;
    model(es, ef);
    if (lng_done) m_pend[lng_done_dest] = 1'b0;
    if (lng_issue && !es && !flush && lng_dest != 0) m_pend[lng_dest] = 1'b1;
    if (es) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_run < TO) m_run++;
      if (m_run == TO) m_hang = 1'b1;
    end else m_run = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < NREG; k++) ep[k] = m_pend[k];
    chk("pending", 64'(pending), 64'(ep));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk("hang", 64'(hang), 64'(m_hang));
  endtask
  task automatic rand_inputs();
    ren_dec = NREAD'($urandom);
    for (int p = 0; p < NREAD; p++) rsel_dec[p*RW +: RW] = RW'($urandom_range(0, 7));
    wsel_ex = RW'($urandom_range(0, 7));
    wsel_mem = RW'($urandom_range(0, 7));
    wsel_wb = RW'($urandom_range(0, 7));
    wen_ex = 1'($urandom); wen_mem = 1'($urandom); wen_wb = 1'($urandom);
    memread_ex = ($urandom_range(0, 3) == 0);
    lng_issue = ($urandom_range(0, 3) == 0);
    lng_dest = RW'($urandom_range(0, 7));
    lng_done = ($urandom_range(0, 2) == 0);
    lng_done_dest = RW'($urandom_range(0, 7));
    flush = ($urandom_range(0, 7) == 0);
  endtask
  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_hang", 64'(hang), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_fwd", 64'(fwd_sel), 64'd0);
    @(posedge clk);
    #1;
    rd(0, 5); wsel_ex = 5; wsel_mem = 5; wsel_wb = 5; wen_ex = 1; wen_mem = 1; wen_wb = 1;
    comb_check();
    chk("prio_ex", 64'(fwd_sel[1:0]), 64'd1);
    chk("prio_ex_stall", 64'(stall), 64'd0);
    clk_step();
    wen_ex = 0;
    comb_check();
    chk("prio_mem", 64'(fwd_sel[1:0]), 64'd2);
    clk_step();
    rsel_dec[RW-1:0] = '0;
    comb_check();
    chk("prio_r0", 64'(fwd_sel[1:0]), 64'd0);
    clk_step();
    idle();
    memread_ex = 1; wen_ex = 1; wsel_ex = 7; rd(1, 7);
    comb_check();
    chk("lu_stall", 64'(stall), 64'd1);
    chk("lu_fwd_ex", 64'(fwd_sel[3:2]), 64'd1);
    chk("lu_cnt0", 64'(stall_cnt), 64'd0);
    clk_step();
    chk("lu_cnt1", 64'(stall_cnt), 64'd1);
    memread_ex = 0; wen_ex = 0; wen_mem = 1; wsel_mem = 7;
    comb_check();
    chk("lu_fwd_mem", 64'(fwd_sel[3:2]), 64'd2);
    chk("lu_release", 64'(stall), 64'd0);
    clk_step();
    idle();
    lng_issue = 1; lng_dest = 9;
    comb_check();
    clk_step();
    chk("sb_set9", 64'(pending[9]), 64'd1);
    idle();
    rd(0, 9);
    comb_check();
    chk("sb_stall", 64'(stall), 64'd1);
    repeat (9) clk_step();
    lng_done = 1; lng_done_dest = 9;
    comb_check();
    clk_step();
    lng_done = 0;
    comb_check();
    chk("sb_release", 64'(stall), 64'd0);
    clk_step();
    idle();
    lng_issue = 1; lng_dest = 3; lng_done = 1; lng_done_dest = 3;
    comb_check();
    clk_step();
    chk("simul_set_wins", 64'(pending[3]), 64'd1);
    comb_check();
    chk("waw_stall", 64'(stall), 64'd1);
    clk_step();
    chk("waw_not_recorded", 64'(pending[3]), 64'd0);
    idle();
    lng_issue = 1; lng_dest = 4; flush = 1;
    comb_check();
    clk_step();
    chk("flush_no_set", 64'(pending[4]), 64'd0);
    idle();
    lng_issue = 1; lng_dest = 10;
    comb_check();
    clk_step();
    idle();
    rd(1, 10);
    comb_check();
    repeat (TO - 1) clk_step();
    chk("hang_early", 64'(hang), 64'd0);
    clk_step();
    chk("hang_rise", 64'(hang), 64'd1);
    lng_done = 1; lng_done_dest = 10;
    clk_step();
    idle();
    comb_check();
    clk_step();
    chk("hang_sticky", 64'(hang), 64'd1);
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      comb_check();
      clk_step();
    end
    idle();
    lng_issue = 1; lng_dest = 12;
    comb_check();
    clk_step();
    idle();
    rd(0, 12);
    #2 rst = 1'b1;
    #1;
    chk("arst_pending", 64'(pending), 64'd0);
    chk("arst_hang", 64'(hang), 64'd0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      comb_check();
      clk_step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard and forwarding controller for the in-order pipeline. It replaces the stall-only hazard unit. It resolves RAW dependencies by forwarding from EX, MEM and WB wherever possible, and stalls decode only for load-use hazards and pending long-latency writes. A register scoreboard tracks outstanding long-latency ops, such as the multiplier, divider or cache miss. A stall watchdog flags pipeline hangs.

## Interface
- NREAD, default 2: number of decode read ports.
- NREG, default 32: architectural register count; register 0 is hardwired zero.
- RW, default $clog2(NREG): register index width.
- CW, default 32: width of the stall performance counter.
- TIMEOUT, default 1024: consecutive stall cycles that raise `hang`.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rsel_dec  in  NREAD×RW  decode source register indices.
- ren_dec  in  NREAD  per-port read enable.
- wsel_ex, wsel_mem, wsel_wb  in  RW each  destination index in each stage.
- wen_ex, wen_mem, wen_wb  in  1 each  the stage writes a register.
- memread_ex  in  1  the instruction in EX is a load.
- lng_issue  in  1  a long-latency op leaves decode this cycle.
- lng_dest  in  RW  destination of the issuing long op.
- lng_done  in  1  a long op completes this cycle.
- lng_done_dest  in  RW  destination of the completing long op.
- flush  in  1  pipeline flush (mispredict).
- stall  out  1  hold PC and IF/ID, bubble ID/EX.
- fwd_sel  out  NREAD×2  per-port operand source.
- pending  out  NREG  scoreboard bits, for debug.
- stall_cnt  out  CW  total stall cycles, saturating.
- hang  out  1  sticky watchdog flag.

## Operation
- fwd_sel encoding: 0 = register file, 1 = EX result, 2 = MEM result, 3 = WB result.
- Port i is active when ren_dec[i]=1 and rsel_dec[i]≠0. An inactive port always gets fwd_sel 0.
- Forward priority is youngest first: EX match with wen_ex, then MEM match with wen_mem, then WB match with wen_wb, otherwise 0.
- Load-use: if an active port matches wsel_ex, with wen_ex=1 and memread_ex=1, assert stall. fwd_sel for that port still reports 1.
- Scoreboard: if an active port's register has its pending bit set, assert stall.
- WAW: if lng_issue=1 and pending[lng_dest]=1, assert stall. In this case the issue is not accepted.
- stall is the OR of the load-use, scoreboard and WAW conditions. It is purely combinational from the inputs and the registered `pending`.
- Scoreboard update, next state:
  - Set pending[lng_dest] when lng_issue & ~stall & ~flush & lng_dest≠0.
  - Clear pending[lng_done_dest] when lng_done.
  - If set and clear target the same register in the same cycle, set wins.
  - Bit 0 is always 0.
- flush does not clear the scoreboard, because long ops already issued still complete. flush suppresses a same-cycle set only.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- Watchdog:
  - An internal run counter increments while stall=1 and resets to 0 whenever stall=0.
  - When the run counter reaches TIMEOUT, hang goes to 1. hang stays 1 until reset.
  - The run counter saturates at TIMEOUT.

## Timing
- Reset values: pending=0, stall_cnt=0, hang=0, run counter=0. stall and fwd_sel are combinational and are 0 under reset if the inputs are idle.
- Reset is asynchronous. Asserting it mid-operation clears the scoreboard immediately, and any pending ops are forgotten.
- Forwarding and stall have 0-cycle latency from the stage inputs.
- Scoreboard latency: a set becomes visible the cycle after lng_issue. A clear releases the stall the cycle after lng_done; the result then forwards via WB.
- A read of the issuing destination in the same cycle as lng_issue is covered by the EX forward or stall path, not by the scoreboard.
- hang rises on the edge where the TIMEOUT-th consecutive stall cycle completes.

## Structure
- hazard_pkg holds:
  - the fwd_sel_t enum: FWD_RF, FWD_EX, FWD_MEM, FWD_WB;
  - the default NREG and RW constants.
- Sub-module hazard_scoreboard holds the NREG-bit pending register with its set/clear logic, and exposes `pending`.
- The top level holds the forwarding comparators (generate loop over NREAD), the stall OR, and both counters.

## Test plan
- Forward priority:
  - Stimulus: rsel_dec[0]=5; wsel_ex=5, wsel_mem=5, wsel_wb=5, all enabled, no load.
  - Required: fwd_sel[0]=1, stall=0.
  - Then disable wen_ex; required: fwd_sel[0]=2.
  - Then rsel_dec[0]=0; required: fwd_sel[0]=0.
- Load-use:
  - Stimulus: memread_ex=1, wsel_ex=7, rsel_dec[1]=7 for one cycle.
  - Required: stall=1 and stall_cnt goes 0→1.
  - Next cycle, with the load moved to MEM: required fwd_sel[1]=2, stall=0.
- Scoreboard:
  - Stimulus: lng_issue with lng_dest=9.
  - Required: pending[9]=1 next cycle; a read of r9 stalls.
  - Stimulus: lng_done with lng_done_dest=9 after 10 cycles.
  - Required: stall=0 the following cycle.
- Simultaneous and WAW:
  - Stimulus: issue r3 and done r3 in the same cycle. Required: pending[3]=1.
  - Stimulus: issue r3 again while it is pending. Required: stall=1, and the issue is not recorded.
  - Stimulus: issue with flush=1. Required: no set.
- Watchdog and reset:
  - Stimulus: hold a scoreboard stall with TIMEOUT=16.
  - Required: hang=1 after 16 stall cycles; it stays 1 after the stall ends.
  - Stimulus: assert rst mid-run.
  - Required: pending=0, hang=0, stall_cnt=0, all immediately.
